instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of instruction buffer entries (power of two, 2 to 8).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset: clk  input  1  clock; reset  input  1  asynchronous active-high reset.
REQ-004 The block SHALL have redirect_valid  input  1  execute requests a PC change this cycle.
REQ-005 The block SHALL have redirect_pc  input  32  new fetch address; bits [1:0] are ignored and treated as 00.
REQ-006 The block SHALL have imem_req  output  1  fetch request.
REQ-007 The block SHALL have imem_addr  output  32  word-aligned fetch address.
REQ-008 The block SHALL have imem_gnt  input  1  memory accepts the request; the address is captured only in a cycle with imem_req=1 and imem_gnt=1.
REQ-009 The block SHALL have imem_rvalid  input  1  response valid, earliest one cycle after the grant.
REQ-010 The block SHALL have imem_rdata  input  32  instruction word.
REQ-011 The block SHALL have instr_valid  output  1  buffer head is valid.
REQ-012 The block SHALL have instr  output  32  instruction word at the buffer head, driven to the decoder instr input.
REQ-013 The block SHALL have instr_pc  output  32  address of instr.
REQ-014 The block SHALL have instr_ready  input  1  decode consumes the head.

Function
REQ-015 The state machine SHALL have four states: IDLE (post-reset), REQ (request phase), WAIT (one response outstanding), DROP (outstanding response to be discarded).
REQ-016 The block SHALL allow at most one outstanding memory request.
REQ-017 imem_req SHALL equal (state==REQ) AND (buffer count < DEPTH), and imem_addr SHALL equal the fetch pc.
- imem_req may deassert, and imem_addr may change, before a grant.
REQ-018 On the first clock edge after reset deasserts, the state SHALL go IDLE -> REQ.
REQ-019 When imem_req=1 and imem_gnt=1 in REQ, the block SHALL set pc to pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0) and move to WAIT.
REQ-020 When imem_rvalid=1 in WAIT, the block SHALL push {pc_of_request, imem_rdata} into the buffer and move to REQ.
- instr_valid rises the next cycle.
- Minimum latency is grant -> rvalid (1 cycle) -> instr_valid (1 cycle), so peak throughput is 1 instruction per 2 cycles.
REQ-021 When instr_valid=1 and instr_ready=1, the block SHALL pop the head; a pop and a push in the same cycle SHALL both take effect.
REQ-022 instr and instr_pc SHALL be held stable while instr_valid=1 and instr_ready=0.
REQ-023 On redirect_valid=1, the block SHALL flush the buffer (instr_valid=0 next cycle) and set pc to {redirect_pc[31:2],2'b00} in that cycle; redirect takes priority over a pop or push in the same cycle.
REQ-024 Redirect transitions SHALL be:
- REQ without grant -> REQ.
- REQ with grant in the same cycle -> DROP.
- WAIT without rvalid -> DROP.
- WAIT with rvalid -> REQ, response discarded.
- DROP -> DROP.
- IDLE -> IDLE, pc updated.
REQ-025 In DROP, imem_rvalid SHALL discard the response and move to REQ; no request is issued while in DROP.
REQ-026 imem_rvalid arriving in IDLE or REQ SHALL be ignored.

Reset
REQ-027 While reset=1, the block SHALL hold: state=IDLE, pc=RESET_PC, buffer empty, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-028 Reset asserted mid-transaction SHALL abandon any outstanding response; a late rvalid falls under REQ-026.

Structure
REQ-029 The fetch state encoding, the instruction width (32), and the NOP constant 32'h0000_0013 SHALL reside in the shared core package.
REQ-030 The buffer SHALL be the sub-module fetch_fifo:
- DEPTH entries of 64 bits {pc, instr}.
- Inputs: push, pop, flush.
- Outputs: count, empty, head.
- Async reset.
- Pointers wrap modulo DEPTH.

Verification
REQ-031 Reset release, imem_gnt=1 always, rvalid one cycle after each grant, instr_ready=1 -> imem_addr sequence 0,4,8; instr_pc follows 0,4,8 with instr equal to the returned words.
REQ-032 instr_ready=0 for 10 cycles -> exactly DEPTH (2) words buffered, imem_req=0 while full, head stable; instr_ready=1 -> in-order drain, requests resume.
REQ-033 Redirect to 32'h0000_0103 while WAIT -> response discarded, next imem_addr=32'h0000_0100, instr_valid stays 0 until the word from 0x100 arrives.
REQ-034 Redirect in the same cycle as rvalid and pop with a full buffer -> buffer empty next cycle, state REQ, no stale instruction is ever presented.
REQ-035 RESET_PC=32'hFFFF_FFFC -> second imem_addr=32'h0000_0000.
REQ-036 Reset asserted during WAIT, then a late rvalid after release -> ignored; first fetch is RESET_PC; imem_req=0 throughout reset.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared core types and constants for the fetch stage
package instruction_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_e;
endpackage

// File: rtl/instruction_fetch_fifo.sv
// fetch_fifo: instruction buffer of {pc, instr} entries with flush
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic [W-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk or posedge reset)
    if (reset || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
  assign empty = count == '0;
  assign head = mem[rd];
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding fetch FSM feeding a small instruction buffer
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_state_e state, state_d;
  logic [XLEN-1:0] pc, pc_d, req_pc;
  logic [CW-1:0] count;
  logic empty, grant, push, pop;
  logic [2*XLEN-1:0] head;
  assign imem_req = state == REQ && count < CW'(DEPTH);
  assign imem_addr = pc;
  assign grant = imem_req && imem_gnt;
  assign push = state == WAIT && imem_rvalid && !redirect_valid;
  assign instr_valid = !empty;
  assign pop = instr_valid && instr_ready && !redirect_valid;
  assign {instr_pc, instr} = instr_valid ? head : '0;
  // a redirect with a request in flight parks in DROP until that response lands
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = redirect_valid ? IDLE : REQ;
      REQ: state_d = grant ? (redirect_valid ? DROP : WAIT) : REQ;
      WAIT: state_d = imem_rvalid ? REQ : (redirect_valid ? DROP : WAIT);
      default: state_d = imem_rvalid ? REQ : DROP;
    endcase
    pc_d = redirect_valid ? (redirect_pc & ~32'd3) : grant ? pc + 32'd4 : pc;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      if (grant) req_pc <= pc;
    end
  fetch_fifo #(.DEPTH(DEPTH), .W(2 * XLEN)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .din({req_pc, imem_rdata}),
    .count(count),
    .empty(empty),
    .head(head)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven and scoreboard checks of the fetch stage
module tb_instruction_fetch;
  logic clk = 0;
  logic reset = 1, redirect_valid = 0, imem_gnt = 0, imem_rvalid = 0, instr_ready = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc;
  logic req2, valid2;
  logic [31:0] addr2, instr2, pc2;
  int vectors = 0, errors = 0, n_gnt = 0;
  bit auto_rsp = 1;
  logic [63:0] q[$];
  typedef struct {
    logic gnt; logic ready;
    logic exp_req; logic [31:0] exp_addr; logic exp_valid; logic [31:0] exp_pc; logic [31:0] exp_addr2;
  } row_t;
  row_t rows[8];
  always #5 clk = ~clk;
  instruction_fetch dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );
  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1), .imem_rvalid(1'b0),
    .imem_rdata(32'h0), .instr_valid(valid2), .instr(instr2), .instr_pc(pc2),
    .instr_ready(1'b1)
  );
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // one clock: score pops and grants at negedge, model memory response after the edge
  task automatic cyc();
    logic g;
    logic [31:0] ga;
    @(negedge clk);
    if (instr_valid && instr_ready && !redirect_valid) begin
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL stale_instr: got %h/%h expected nothing", instr_pc, instr);
      end else chk("sb_instr", {instr_pc, instr}, q.pop_front());
    end
    if (redirect_valid) q.delete();
    g = imem_req && imem_gnt;
    ga = imem_addr;
    if (g) n_gnt++;
    if (g && !redirect_valid) q.push_back({ga, word(ga)});
    @(posedge clk);
    #1;
    redirect_valid = 0;
    if (auto_rsp) begin
      imem_rvalid = g;
      imem_rdata = g ? word(ga) : 32'h0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int g0;
    rows[0] = '{1, 1, 0, 32'h0, 0, 32'h0, 32'hFFFF_FFFC};
    rows[1] = '{1, 1, 1, 32'h0, 0, 32'h0, 32'hFFFF_FFFC};
    rows[2] = '{1, 1, 0, 32'h4, 0, 32'h0, 32'h0};
    rows[3] = '{1, 1, 1, 32'h4, 1, 32'h0, 32'h0};
    rows[4] = '{1, 1, 0, 32'h8, 0, 32'h0, 32'h0};
    rows[5] = '{1, 1, 1, 32'h8, 1, 32'h4, 32'h0};
    rows[6] = '{1, 1, 0, 32'hC, 0, 32'h0, 32'h0};
    rows[7] = '{1, 1, 1, 32'hC, 1, 32'h8, 32'h0};
    imem_gnt = 1;
    repeat (3) begin
      cyc();
      chk("rst_req", 64'(imem_req), 64'(0));
      chk("rst_addr", 64'(imem_addr), 64'(0));
      chk("rst_out", {instr_pc, instr}, 64'(0));
      chk("rst_valid", 64'(instr_valid), 64'(0));
      chk("rst_addr2", 64'(addr2), 64'(32'hFFFF_FFFC));
    end
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      imem_gnt = rows[i].gnt;
      instr_ready = rows[i].ready;
      #1;
      chk("row_req", 64'(imem_req), 64'(rows[i].exp_req));
      chk("row_addr", 64'(imem_addr), 64'(rows[i].exp_addr));
      chk("row_valid", 64'(instr_valid), 64'(rows[i].exp_valid));
      if (rows[i].exp_valid) chk("row_pc", 64'(instr_pc), 64'(rows[i].exp_pc));
      chk("row_addr2", 64'(addr2), 64'(rows[i].exp_addr2));
      cyc();
    end
    instr_ready = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("bp_valid", 64'(instr_valid), 64'(1));
      chk("bp_head", {instr_pc, instr}, {32'hC, word(32'hC)});
    end
    chk("bp_req_full", 64'(imem_req), 64'(0));
    chk("bp_count", 64'(q.size()), 64'(2));
    g0 = n_gnt;
    instr_ready = 1;
    repeat (8) cyc();
    chk("bp_resume", 64'(n_gnt > g0 + 1), 64'(1));
    imem_gnt = 0;
    repeat (4) cyc();
    auto_rsp = 0;
    imem_rvalid = 0;
    chk("rd_req", 64'(imem_req), 64'(1));
    chk("rd_empty", 64'(instr_valid), 64'(0));
    imem_gnt = 1;
    cyc();
    imem_gnt = 0;
    redirect_valid = 1;
    redirect_pc = 32'h0000_0103;
    chk("rd_wait_req", 64'(imem_req), 64'(0));
    cyc();
    chk("rd_drop_req", 64'(imem_req), 64'(0));
    chk("rd_drop_addr", 64'(imem_addr), 64'(32'h100));
    imem_rvalid = 1;
    imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_rvalid = 0;
    chk("rd_req2", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h100});
    chk("rd_novalid", 64'(instr_valid), 64'(0));
    imem_gnt = 1;
    cyc();
    imem_gnt = 0;
    imem_rvalid = 1;
    imem_rdata = word(32'h100);
    chk("rd_novalid2", 64'(instr_valid), 64'(0));
    cyc();
    imem_rvalid = 0;
    instr_ready = 0;
    chk("rd_valid", 64'(instr_valid), 64'(1));
    chk("rd_head", {instr_pc, instr}, {32'h100, word(32'h100)});
    chk("sq_req", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h104});
    imem_gnt = 1;
    cyc();
    imem_gnt = 0;
    imem_rvalid = 1;
    imem_rdata = word(32'h104);
    redirect_valid = 1;
    redirect_pc = 32'h0000_0200;
    instr_ready = 1;
    cyc();
    imem_rvalid = 0;
    chk("sq_flush", 64'(instr_valid), 64'(0));
    chk("sq_req2", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h200});
    auto_rsp = 1;
    imem_gnt = 1;
    repeat (6) cyc();
    imem_gnt = 0;
    repeat (4) cyc();
    auto_rsp = 0;
    chk("rs_req", 64'(imem_req), 64'(1));
    imem_gnt = 1;
    cyc();
    reset = 1;
    q.delete();
    #1;
    chk("rs_req0", 64'(imem_req), 64'(0));
    chk("rs_out", {31'h0, instr_valid, imem_addr}, 64'(0));
    repeat (2) begin
      cyc();
      chk("rs_hold", {31'h0, imem_req, imem_addr}, 64'(0));
      chk("rs_outs", {instr_pc, instr}, 64'(0));
    end
    reset = 0;
    imem_gnt = 0;
    imem_rvalid = 1;
    imem_rdata = 32'hBAD0_0000;
    cyc();
    chk("rs_first", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
    cyc();
    imem_rvalid = 0;
    chk("rs_ignored", 64'(instr_valid), 64'(0));
    chk("rs_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
    auto_rsp = 1;
    imem_gnt = 1;
    repeat (4) cyc();
    imem_gnt = 0;
    repeat (4) cyc();
    chk("final_drain", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
